// File: rtl/rib_rr_arbiter.sv
`timescale 1ns/1ps
// rib_rr_arbiter: round-robin arbiter sharing the RIB slave bus among four masters, with
// bounded locking and core stall flag. Define RIB_ARB_URGENT_EN to add urgent_i preemption.
module rib_rr_arbiter #(
  parameter int unsigned          N_MASTER  = 4,
  parameter int unsigned          MAX_HOLD  = 16,
  parameter logic [N_MASTER-1:0]  CORE_MASK = 4'b0011
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTER-1:0]          req_i,
  input  logic [N_MASTER-1:0]          lock_i,
`ifdef RIB_ARB_URGENT_EN
  input  logic [N_MASTER-1:0]          urgent_i,
`endif
  output logic [N_MASTER-1:0]          grant_o,
  output logic [$clog2(N_MASTER)-1:0]  grant_idx_o,
  output logic                         grant_vld_o,
  output logic                         hold_flag_o
);

  localparam int unsigned IdxW     = $clog2(N_MASTER);
  localparam logic [7:0]  HoldLast = 8'(MAX_HOLD - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [N_MASTER-1:0] urg;
  logic [N_MASTER-1:0] others;
  logic [IdxW-1:0]     win;
  logic                new_grant;
  logic                release_bus;

`ifdef RIB_ARB_URGENT_EN
  assign urg = urgent_i;
`else
  assign urg = '0;
`endif

  // Urgent requesters, if any, form the candidate set; otherwise all requesters do.
  function automatic logic [IdxW-1:0] rr_pick(input logic [N_MASTER-1:0] set,
                                              input logic [N_MASTER-1:0] urgent,
                                              input logic [IdxW-1:0]     ptr);
    logic [N_MASTER-1:0] cand;
    logic [IdxW-1:0]     idx;
    cand    = (|(set & urgent)) ? (set & urgent) : set;
    rr_pick = ptr;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      idx = ptr + IdxW'(i);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  // In idle grant_q is zero, so others covers every requester.
  assign others = req_i & ~grant_q;
  assign win    = rr_pick(others, urg, ptr_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    new_grant   = 1'b0;
    release_bus = 1'b0;

    case (state_q)
      StIdle: new_grant = |req_i;
      StOwn: begin
        if (!req_i[idx_q]) begin
          if (|others) new_grant = 1'b1;
          else         release_bus = 1'b1;
        end else if (!urg[idx_q] && |(others & urg)) begin
          new_grant = 1'b1;
        end else if (lock_i[idx_q] && (cnt_q < HoldLast)) begin
          cnt_d = cnt_q + 8'd1;
        end else if (|others) begin
          new_grant = 1'b1;
        end else if (cnt_q < HoldLast) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: release_bus = 1'b1;
    endcase

    if (new_grant) begin
      state_d = StOwn;
      grant_d = N_MASTER'(1) << win;
      idx_d   = win;
      ptr_d   = win + IdxW'(1);
      cnt_d   = '0;
    end else if (release_bus) begin
      state_d = StIdle;
      grant_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_vld_o = (state_q == StOwn);
  assign hold_flag_o = (|(req_i & CORE_MASK & ~grant_q)) & grant_vld_o &
                       ~(|(grant_q & CORE_MASK));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
`timescale 1ns/1ps
// Directed bench for rib_rr_arbiter: vector table for rotation/handover, hand sequences for
// lock bound, lone lock, async reset and (optionally) urgent preemption.
module tb_rib_rr_arbiter;

  localparam int unsigned MaxHold = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       hold_flag;
`ifdef RIB_ARB_URGENT_EN
  logic [3:0] urgent;
`endif

  int passed = 0;
  int total  = 0;
  int held;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       vld;
    logic       hold;
  } vec_t;

  vec_t vecs[15];

  rib_rr_arbiter #(
    .N_MASTER  (4),
    .MAX_HOLD  (MaxHold),
    .CORE_MASK (4'b0011)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .lock_i      (lock),
`ifdef RIB_ARB_URGENT_EN
    .urgent_i    (urgent),
`endif
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld),
    .hold_flag_o (hold_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: rotation with 0110, full rotation with 1111, same-cycle handover, drop to idle.
    vecs[0]  = '{4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[2]  = '{4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[13] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 4'b0110;
    lock  = 4'b0000;
`ifdef RIB_ARB_URGENT_EN
    urgent = 4'b0000;
`endif
    #1;
    check("reset grant", int'(grant), 0);
    check("reset idx",   int'(grant_idx), 0);
    check("reset vld",   int'(grant_vld), 0);
    check("reset hold",  int'(hold_flag), 0);
    tick();
    tick();
    check("reset grant held over clocks", int'(grant), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req  = vecs[i].req;
      lock = vecs[i].lock;
      tick();
      check($sformatf("vec%0d grant", i), int'(grant),     int'(vecs[i].grant));
      check($sformatf("vec%0d idx", i),   int'(grant_idx), int'(vecs[i].idx));
      check($sformatf("vec%0d vld", i),   int'(grant_vld), int'(vecs[i].vld));
      check($sformatf("vec%0d hold", i),  int'(hold_flag), int'(vecs[i].hold));
    end

    // Lock bound: m2 locked with everyone waiting keeps the bus MaxHold cycles, then m3.
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    check("lock m2 grant", int'(grant), 4'b0100);
    req  = 4'b1111;
    held = 1;
    for (int i = 0; i < 3 * MaxHold; i++) begin
      tick();
      if (grant != 4'b0100) break;
      held++;
    end
    check("lock bound cycles", held, MaxHold);
    check("after lock bound grant", int'(grant), 4'b1000);

    // Lone locked owner is never released.
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    check("lone lock grant", int'(grant), 4'b0100);
    held = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (grant == 4'b0100) held++;
    end
    check("lone lock cycles", held, 100);

    // Async reset mid-lock while the core is stalled.
    #1;
    req = 4'b0101;
    #1;
    check("stall before reset", int'(hold_flag), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset grant", int'(grant),     0);
    check("async reset vld",   int'(grant_vld), 0);
    check("async reset idx",   int'(grant_idx), 0);
    check("async reset hold",  int'(hold_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    lock  = 4'b0000;
    tick();
    check("post reset ptr grant", int'(grant), 4'b0001);
    check("post reset idx",       int'(grant_idx), 0);

    // m1 locked owner with m3 waiting (urgent when the feature is built).
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    check("m1 lock grant", int'(grant), 4'b0010);
    req = 4'b1010;
`ifdef RIB_ARB_URGENT_EN
    urgent = 4'b1000;
    tick();
    check("urgent preempt grant", int'(grant), 4'b1000);
`else
    held = 1;
    for (int i = 0; i < 3 * MaxHold; i++) begin
      tick();
      if (grant != 4'b0010) break;
      held++;
    end
    check("m1 lock cycles", held, MaxHold);
    check("after m1 lock grant", int'(grant), 4'b1000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
